iir_output_stage: RTL and testbench

- Downstream consumer of the second-order IIR section's raw accumulator output `y`.
- Rescales by an arithmetic right shift with rounding, then saturates to a narrower output word.
- Decimates by a fixed factor and buffers kept samples in a small FIFO.
- Presents the FIFO contents on a valid/ready stream, so downstream logic (DAC serializer, UART dump, next cascade stage) can apply backpressure without stalling the filter.

---
 rtl/iir_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/iir_output_stage.sv | 103 ++++++++++
 tb/tb_iir_output_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared widths and constant helpers for the IIR cascade output path.
package iir_pkg;

  localparam int BITWIDTH  = 32;
  localparam int OUT_WIDTH = 16;
  localparam int SHIFT     = 20;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Largest and smallest value representable in a w-bit two's-complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; pushes into a full FIFO are only
// accepted alongside a pop, and pops of an empty FIFO are ignored.
module sync_fifo
  import iir_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(depth):0]  level
);

  localparam int aw = clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when nothing is queued, so reset shows a clean bus.
  assign dout    = empty ? '0 : mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[aw-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (aw + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (aw + 1)'(1);
    end
  end

endmodule

// File: rtl/iir_output_stage.sv
// Rescale (round + arithmetic shift), saturate and decimate the IIR accumulator
// output, then queue kept samples behind a valid/ready stream.
module iir_output_stage
  import iir_pkg::*;
#(
  parameter int bitwidth   = BITWIDTH,
  parameter int out_width  = OUT_WIDTH,
  parameter int shift      = SHIFT,
  parameter int decim      = 4,
  parameter int fifo_depth = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_en,
  input  logic signed [bitwidth-1:0]        y_in,
  input  logic                              clr,
  output logic signed [out_width-1:0]       out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [clog2(fifo_depth):0]        level,
  output logic                              sat_flag,
  output logic                              ovf_flag
);

  localparam int cw = (decim > 1) ? clog2(decim) : 1;

  // One guard bit above the input keeps the rounding bias from wrapping.
  typedef logic signed [bitwidth:0] ext_t;

  localparam ext_t sat_hi = ext_t'(sat_max(out_width));
  localparam ext_t sat_lo = ext_t'(sat_min(out_width));
  localparam ext_t bias   = (shift > 0) ? (ext_t'(1) <<< ((shift > 0) ? shift - 1 : 0)) : ext_t'(0);

  function automatic ext_t round_shift(input logic signed [bitwidth-1:0] x);
    ext_t s;
    s = ext_t'(x) + bias;
    return s >>> shift;
  endfunction

  function automatic logic signed [out_width-1:0] saturate(input ext_t r);
    if (r > sat_hi) return sat_hi[out_width-1:0];
    if (r < sat_lo) return sat_lo[out_width-1:0];
    return r[out_width-1:0];
  endfunction

  ext_t                         r_p0;
  logic                         clip_p0;
  logic [cw-1:0]                cnt;
  logic signed [out_width-1:0]  data_p1;
  logic                         vld_p1;
  logic                         full;
  logic                         empty;
  logic                         pop;

  assign r_p0    = round_shift(y_in);
  assign clip_p0 = (r_p0 > sat_hi) || (r_p0 < sat_lo);

  // Stage 1: rounded/saturated sample registered, kept only at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_en && (cnt == '0);
      if (in_en) begin
        data_p1 <= saturate(r_p0);
        cnt     <= (cnt == cw'(decim - 1)) ? '0 : cnt + cw'(1);
      end
    end
  end

  // Stage 2: FIFO write; a kept sample is lost only if full with no pop.
  assign pop       = out_ready && !empty;
  assign out_valid = !empty;

  sync_fifo #(
    .width (out_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p1),
    .pop   (out_ready),
    .din   (data_p1),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Sticky flags: a set event in the same cycle as clr takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      sat_flag <= (sat_flag && !clr) || (in_en && clip_p0);
      ovf_flag <= (ovf_flag && !clr) || (vld_p1 && full && !pop);
    end
  end

endmodule

// File: tb/tb_iir_output_stage.sv
// Directed bench for iir_output_stage: three instances cover decimation,
// rounding/backpressure and saturation with hand-computed expectations.
module tb_iir_output_stage;

  logic clk;
  logic rst_n;
  logic clr;

  logic               en4, rdy4, ov4, sf4, of4;
  logic signed [31:0] y4;
  logic signed [15:0] od4;
  logic [3:0]         lv4;

  logic               en1, rdy1, ov1, sf1, of1;
  logic signed [31:0] y1;
  logic signed [15:0] od1;
  logic [3:0]         lv1;

  logic               ens, rdys, ovs, sfs, ofs;
  logic signed [31:0] ys;
  logic signed [15:0] ods;
  logic [3:0]         lvs;

  int n_pass;
  int n_total;

  iir_output_stage #(.decim(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_en(en4), .y_in(y4), .clr(clr),
    .out_data(od4), .out_valid(ov4), .out_ready(rdy4), .level(lv4),
    .sat_flag(sf4), .ovf_flag(of4)
  );

  iir_output_stage #(.decim(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_en(en1), .y_in(y1), .clr(clr),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .level(lv1),
    .sat_flag(sf1), .ovf_flag(of1)
  );

  iir_output_stage #(.decim(1), .shift(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_en(ens), .y_in(ys), .clr(clr),
    .out_data(ods), .out_valid(ovs), .out_ready(rdys), .level(lvs),
    .sat_flag(sfs), .ovf_flag(ofs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++;
    if (ov4 !== 1'b0 || od4 !== 16'sd0 || lv4 !== 4'd0 || sf4 !== 1'b0 || of4 !== 1'b0)
      $display("FAIL reset_d4: got v=%b d=%0d l=%0d s=%b o=%b want all zero", ov4, od4, lv4, sf4, of4);
    else n_pass++;
    n_total++;
    if (ov1 !== 1'b0 || od1 !== 16'sd0 || lv1 !== 4'd0 || sf1 !== 1'b0 || of1 !== 1'b0)
      $display("FAIL reset_d1: got v=%b d=%0d l=%0d s=%b o=%b want all zero", ov1, od1, lv1, sf1, of1);
    else n_pass++;
    n_total++;
    if (ovs !== 1'b0 || ods !== 16'sd0 || lvs !== 4'd0 || sfs !== 1'b0 || ofs !== 1'b0)
      $display("FAIL reset_sat: got v=%b d=%0d l=%0d s=%b o=%b want all zero", ovs, ods, lvs, sfs, ofs);
    else n_pass++;
  endtask

  task automatic test_decim();
    logic exp_v;
    rdy4 = 1'b1;
    y4   = 32'sd3 <<< 20;
    en4  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_v = (k % 4 == 2);
      n_total++;
      if (ov4 !== exp_v) $display("FAIL decim_valid k=%0d: got %b want %b", k, ov4, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_total++;
        if (od4 !== 16'sd3) $display("FAIL decim_data k=%0d: got %0d want 3", k, od4);
        else n_pass++;
      end
    end
    en4 = 1'b0;
    tick();
    tick();
    n_total++;
    if (sf4 !== 1'b0 || ov4 !== 1'b0) $display("FAIL decim_end: got sat=%b valid=%b want 0 0", sf4, ov4);
    else n_pass++;
  endtask

  task automatic test_rounding();
    logic signed [31:0] rv [4];
    logic signed [15:0] re [4];
    rv = '{32'sh0018_0000, 32'sh0017_FFFF, -32'sh0018_0000, -32'sh0018_0001};
    re = '{16'sd2, 16'sd1, -16'sd1, -16'sd2};
    rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y1  = rv[i];
      en1 = 1'b1;
      tick();
      en1 = 1'b0;
      tick();
      n_total++;
      if (ov1 !== 1'b1 || od1 !== re[i])
        $display("FAIL round_%0d: got valid=%b data=%0d want valid=1 data=%0d", i, ov1, od1, re[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (sf1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL round_end: got sat=%b valid=%b want 0 0", sf1, ov1);
    else n_pass++;
    rdy1 = 1'b0;
  endtask

  task automatic test_saturation();
    rdys = 1'b1;
    ys   = 32'sh7FFF_FFFF;
    ens  = 1'b1;
    tick();
    ens = 1'b0;
    tick();
    n_total++;
    if (ods !== 16'sd32767 || sfs !== 1'b1)
      $display("FAIL sat_pos: got data=%0d sat=%b want 32767 1", ods, sfs);
    else n_pass++;
    tick();
    ys  = 32'sh8000_0000;
    ens = 1'b1;
    tick();
    ens = 1'b0;
    tick();
    n_total++;
    if (ods !== -16'sd32768) $display("FAIL sat_neg: got %0d want -32768", ods);
    else n_pass++;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_total++;
    if (sfs !== 1'b0) $display("FAIL sat_clr: got %b want 0", sfs);
    else n_pass++;
    // In-range sample must not re-arm the flag.
    ys  = 32'sh0000_0100;
    ens = 1'b1;
    tick();
    ens = 1'b0;
    tick();
    n_total++;
    if (ods !== 16'sd1 || sfs !== 1'b0) $display("FAIL sat_inrange: got data=%0d sat=%b want 1 0", ods, sfs);
    else n_pass++;
    tick();
    // Set and clear in the same cycle: set wins.
    ys  = 32'sh7FFF_FFFF;
    ens = 1'b1;
    clr = 1'b1;
    tick();
    ens = 1'b0;
    clr = 1'b0;
    n_total++;
    if (sfs !== 1'b1) $display("FAIL sat_set_wins: got %b want 1", sfs);
    else n_pass++;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rdys = 1'b0;
  endtask

  task automatic test_backpressure();
    rdy1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      y1  = i <<< 20;
      en1 = 1'b1;
      tick();
    end
    en1 = 1'b0;
    tick();
    tick();
    n_total++;
    if (lv1 !== 4'd8 || of1 !== 1'b1 || ov1 !== 1'b1)
      $display("FAIL bp_full: got level=%0d ovf=%b valid=%b want 8 1 1", lv1, of1, ov1);
    else n_pass++;
    rdy1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_total++;
      if (ov1 !== 1'b1 || od1 !== 16'(i))
        $display("FAIL bp_drain_%0d: got valid=%b data=%0d want 1 %0d", i, ov1, od1, i);
      else n_pass++;
      tick();
    end
    n_total++;
    if (ov1 !== 1'b0 || lv1 !== 4'd0) $display("FAIL bp_empty: got valid=%b level=%0d want 0 0", ov1, lv1);
    else n_pass++;
    rdy1 = 1'b0;
  endtask

  task automatic test_full_pop();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_total++;
    if (of1 !== 1'b0) $display("FAIL fp_clr: got ovf=%b want 0", of1);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      y1  = (i + 20) <<< 20;
      en1 = 1'b1;
      tick();
    end
    en1 = 1'b0;
    tick();
    n_total++;
    if (lv1 !== 4'd8) $display("FAIL fp_fill: got level=%0d want 8", lv1);
    else n_pass++;
    y1  = 32'sd99 <<< 20;
    en1 = 1'b1;
    tick();
    en1  = 1'b0;
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    n_total++;
    if (lv1 !== 4'd8 || of1 !== 1'b0 || od1 !== 16'sd22)
      $display("FAIL fp_pushpop: got level=%0d ovf=%b head=%0d want 8 0 22", lv1, of1, od1);
    else n_pass++;
    rdy1 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_total++;
    if (od1 !== 16'sd99 || ov1 !== 1'b1) $display("FAIL fp_tail: got data=%0d valid=%b want 99 1", od1, ov1);
    else n_pass++;
    tick();
    n_total++;
    if (ov1 !== 1'b0) $display("FAIL fp_empty: got valid=%b want 0", ov1);
    else n_pass++;
    rdy1 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i <= 5; i++) begin
      y1  = i <<< 20;
      en1 = 1'b1;
      tick();
    end
    en1 = 1'b0;
    // Leave the decim-4 counter at phase 2 and arm the sat flag.
    rdy4 = 1'b1;
    y4   = 32'sd7 <<< 20;
    en4  = 1'b1;
    ys   = 32'sh7FFF_FFFF;
    ens  = 1'b1;
    tick();
    ens = 1'b0;
    tick();
    en4 = 1'b0;
    tick();
    tick();
    n_total++;
    if (lv1 !== 4'd5 || sfs !== 1'b1) $display("FAIL mid_pre: got level=%0d sat=%b want 5 1", lv1, sfs);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ov1 !== 1'b0 || lv1 !== 4'd0 || od1 !== 16'sd0 || sfs !== 1'b0 || lvs !== 4'd0)
      $display("FAIL mid_async: got valid=%b level=%0d data=%0d sat=%b want 0 0 0 0", ov1, lv1, od1, sfs);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    y4  = 32'sd5 <<< 20;
    en4 = 1'b1;
    tick();
    en4 = 1'b0;
    n_total++;
    if (ov4 !== 1'b0) $display("FAIL mid_latency: got valid=%b want 0", ov4);
    else n_pass++;
    tick();
    n_total++;
    if (ov4 !== 1'b1 || od4 !== 16'sd5) $display("FAIL mid_first_kept: got valid=%b data=%0d want 1 5", ov4, od4);
    else n_pass++;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    en4 = 1'b0; rdy4 = 1'b0; y4 = '0;
    en1 = 1'b0; rdy1 = 1'b0; y1 = '0;
    ens = 1'b0; rdys = 1'b0; ys = '0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    test_decim();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
